// File: rtl/coin_return_dispenser_pkg.sv
// coin_return_dispenser_pkg: shared widths, coin values, one-hot coin codes and FSM states
package coin_return_dispenser_pkg;
  localparam int kTotalBits = 16;
  localparam int kNumCoins = 3;
  localparam int kVal100 = 100;
  localparam int kVal500 = 500;
  localparam int kVal1000 = 1000;
  localparam logic [kNumCoins-1:0] kCoin100 = 3'b001;
  localparam logic [kNumCoins-1:0] kCoin500 = 3'b010;
  localparam logic [kNumCoins-1:0] kCoin1000 = 3'b100;
`ifdef HOPPER_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, SELECT, OFFER, DONE, FAULT} state_t;
`else
  typedef enum logic [2:0] {IDLE, SELECT, OFFER, DONE} state_t;
`endif
endpackage

// File: rtl/coin_return_dispenser_coin_select.sv
// coin_return_dispenser_coin_select: largest coin that fits the remaining amount, with its value
module coin_return_dispenser_coin_select
  import coin_return_dispenser_pkg::*;
#(
  parameter int TOTAL_BITS = kTotalBits,
  parameter int NUM_COINS = kNumCoins
) (
  input  logic [TOTAL_BITS-1:0] remaining,
  output logic [NUM_COINS-1:0]  coin,
  output logic [TOTAL_BITS-1:0] value
);
  logic ge1000, ge500, ge100;
  assign ge1000 = remaining >= TOTAL_BITS'(kVal1000);
  assign ge500 = remaining >= TOTAL_BITS'(kVal500);
  assign ge100 = remaining >= TOTAL_BITS'(kVal100);
  always_comb begin
    coin = ge1000 ? NUM_COINS'(kCoin1000) : ge500 ? NUM_COINS'(kCoin500) :
           ge100 ? NUM_COINS'(kCoin100) : '0;
    value = ge1000 ? TOTAL_BITS'(kVal1000) : ge500 ? TOTAL_BITS'(kVal500) :
            ge100 ? TOTAL_BITS'(kVal100) : '0;
  end
endmodule

// File: rtl/coin_return_dispenser.sv
// coin_return_dispenser: greedy coin refund over a valid/ready hopper handshake.
// Optional hopper timeout with sticky fault when HOPPER_TIMEOUT_EN is defined.
module coin_return_dispenser
  import coin_return_dispenser_pkg::*;
#(
  parameter int TOTAL_BITS = kTotalBits,
  parameter int NUM_COINS = kNumCoins,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_return_req,
  input  logic [TOTAL_BITS-1:0] i_total,
  output logic                  o_hopper_valid,
  input  logic                  i_hopper_ready,
  output logic [NUM_COINS-1:0]  o_hopper_coin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [TOTAL_BITS-1:0] o_dispensed,
  output logic [TOTAL_BITS-1:0] o_remaining,
  output logic                  o_fault
);
  state_t state, state_n;
  logic [NUM_COINS-1:0] coin, coin_n, sel_coin;
  logic [TOTAL_BITS-1:0] rem, rem_n, disp, disp_n, sel_val;
  coin_return_dispenser_coin_select #(
    .TOTAL_BITS(TOTAL_BITS),
    .NUM_COINS(NUM_COINS)
  ) u_sel (
    .remaining(rem),
    .coin(sel_coin),
    .value(sel_val)
  );
`ifdef HOPPER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= cnt_n;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      coin <= '0;
      rem <= '0;
      disp <= '0;
    end else begin
      state <= state_n;
      coin <= coin_n;
      rem <= rem_n;
      disp <= disp_n;
    end
  // rem is stable between SELECT and acceptance, so sel_val is the offered coin's value
  always_comb begin
    state_n = state;
    coin_n = coin;
    rem_n = rem;
    disp_n = disp;
`ifdef HOPPER_TIMEOUT_EN
    cnt_n = '0;
`endif
    case (state)
      IDLE: if (i_return_req) begin
        rem_n = i_total;
        disp_n = '0;
        state_n = SELECT;
      end
      SELECT: begin
        coin_n = sel_coin;
        state_n = sel_coin == '0 ? DONE : OFFER;
      end
      OFFER: if (i_hopper_ready) begin
        rem_n = rem - sel_val;
        disp_n = disp + sel_val;
        coin_n = '0;
        state_n = SELECT;
      end
`ifdef HOPPER_TIMEOUT_EN
      else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        coin_n = '0;
        state_n = FAULT;
      end else cnt_n = cnt + 1'b1;
`endif
      DONE: state_n = IDLE;
      default: state_n = state;
    endcase
  end
  assign o_hopper_valid = state == OFFER;
  assign o_hopper_coin = coin;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  assign o_dispensed = disp;
  assign o_remaining = rem;
`ifdef HOPPER_TIMEOUT_EN
  assign o_fault = state == FAULT;
`else
  assign o_fault = 1'b0;
`endif
endmodule

// File: tb/tb_coin_return_dispenser.sv
// tb_coin_return_dispenser: random + directed refunds checked against a transaction-level greedy model
module tb_coin_return_dispenser;
  logic clk = 0, reset = 1, i_return_req = 0, i_hopper_ready = 0;
  logic [15:0] i_total = 0;
  logic o_hopper_valid, o_busy, o_done, o_fault;
  logic [2:0] o_hopper_coin;
  logic [15:0] o_dispensed, o_remaining;
  int total_c = 0, bad_c = 0;
  coin_return_dispenser dut (
    .clk(clk), .reset(reset), .i_return_req(i_return_req), .i_total(i_total),
    .o_hopper_valid(o_hopper_valid), .i_hopper_ready(i_hopper_ready),
    .o_hopper_coin(o_hopper_coin), .o_busy(o_busy), .o_done(o_done),
    .o_dispensed(o_dispensed), .o_remaining(o_remaining), .o_fault(o_fault)
  );
  always #5 clk = ~clk;
  // model: refund as a queue of greedy coin values; m_cur is the coin on offer (0 = none)
  bit m_busy, m_done, m_off;
  int m_cur, m_rem, m_disp;
  int m_q[$];
  logic [2:0] seen[$];
  function automatic logic [2:0] enc(int v);
    return v == 1000 ? 3'b100 : v == 500 ? 3'b010 : v == 100 ? 3'b001 : 3'b000;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total_c++;
    if (act !== exp) begin
      bad_c++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_done = 0; m_cur = 0; m_rem = 0; m_disp = 0; m_q.delete();
  endtask
  task automatic model_step(logic req, int tot, logic rdy);
    if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (req) begin
        m_busy = 1; m_rem = tot; m_disp = 0; m_q.delete();
        repeat (tot / 1000) m_q.push_back(1000);
        repeat ((tot % 1000) / 500) m_q.push_back(500);
        repeat ((tot % 500) / 100) m_q.push_back(100);
      end
    end else if (m_cur == 0) begin
      if (m_q.size() == 0) m_done = 1;
      else m_cur = m_q.pop_front();
    end else if (rdy) begin
      m_rem -= m_cur;
      m_disp += m_cur;
      m_cur = 0;
    end
  endtask
  task automatic compare();
    if (m_off) return;
    chk("valid", 32'(o_hopper_valid), 32'(m_cur != 0));
    chk("coin", 32'(o_hopper_coin), 32'(enc(m_cur)));
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("done", 32'(o_done), 32'(m_done));
    chk("dispensed", 32'(o_dispensed), 32'(m_disp));
    chk("remaining", 32'(o_remaining), 32'(m_rem));
    chk("fault", 32'(o_fault), 32'd0);
  endtask
  task automatic cycle(logic req, int tot, logic rdy);
    compare();
    i_return_req = req;
    i_total = 16'(tot);
    i_hopper_ready = rdy;
    model_step(req, tot, rdy);
    @(negedge clk);
  endtask
  // returns i such that o_done was seen in cycle N+i (N = request edge)
  task automatic run_refund(int tot, int stall, bit inject, output int lat, output int nvalid);
    int i, st;
    logic r;
    seen.delete();
    st = stall;
    nvalid = 0;
    cycle(1, tot, 0);
    i = 1;
    while (o_done !== 1'b1 && i < 400) begin
      r = 1;
      if (o_hopper_valid) nvalid++;
      if (o_hopper_valid && st > 0) begin r = 0; st--; end
      if (o_hopper_valid && r) seen.push_back(o_hopper_coin);
      cycle(inject && o_hopper_valid, 1234, r);
      i++;
    end
    lat = i;
  endtask
  task automatic async_reset();
    i_return_req = 0;
    i_hopper_ready = 0;
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("ar_valid", 32'(o_hopper_valid), 0);
    chk("ar_coin", 32'(o_hopper_coin), 0);
    chk("ar_busy", 32'(o_busy), 0);
    chk("ar_done", 32'(o_done), 0);
    chk("ar_disp", 32'(o_dispensed), 0);
    chk("ar_rem", 32'(o_remaining), 0);
    chk("ar_fault", 32'(o_fault), 0);
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    int lat, nv, tot;
    logic [2:0] exp1700[4];
    exp1700[0] = 3'b100; exp1700[1] = 3'b010; exp1700[2] = 3'b001; exp1700[3] = 3'b001;
    m_off = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_valid", 32'(o_hopper_valid), 0);
    chk("rst_rem", 32'(o_remaining), 0);
    cycle(0, 0, 0);
    run_refund(1700, 0, 0, lat, nv);
    chk("1700_lat", lat, 10);
    chk("1700_ncoin", seen.size(), 4);
    for (int k = 0; k < 4 && k < seen.size(); k++) chk("1700_coin", 32'(seen[k]), 32'(exp1700[k]));
    chk("1700_disp", 32'(o_dispensed), 1700);
    chk("1700_rem", 32'(o_remaining), 0);
    cycle(0, 0, 0);
    run_refund(650, 0, 0, lat, nv);
    chk("650_lat", lat, 6);
    chk("650_ncoin", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("650_c0", 32'(seen[0]), 32'b010);
      chk("650_c1", 32'(seen[1]), 32'b001);
    end
    chk("650_disp", 32'(o_dispensed), 600);
    chk("650_rem", 32'(o_remaining), 50);
    cycle(0, 0, 0);
    run_refund(1000, 5, 0, lat, nv);
    chk("1000_lat", lat, 9);
    chk("1000_nvalid", nv, 6);
    chk("1000_disp", 32'(o_dispensed), 1000);
    cycle(0, 0, 0);
    run_refund(50, 0, 0, lat, nv);
    chk("50_lat", lat, 2);
    chk("50_nvalid", nv, 0);
    chk("50_rem", 32'(o_remaining), 50);
    chk("50_disp", 32'(o_dispensed), 0);
    cycle(0, 0, 0);
    run_refund(1500, 0, 1, lat, nv);
    chk("1500_lat", lat, 6);
    chk("1500_disp", 32'(o_dispensed), 1500);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("1500_idle", 32'(o_busy), 0);
    chk("1500_hold", 32'(o_dispensed), 1500);
    cycle(1, 1500, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("pre_ar_valid", 32'(o_hopper_valid), 1);
    async_reset();
    for (int c = 0; c < 3000; c++) begin
      tot = $urandom_range(0, 3) == 0 ? $urandom_range(0, 99) : $urandom_range(0, 4999);
      cycle($urandom_range(0, 3) == 0, tot, $urandom_range(0, 1));
    end
    for (int c = 0; c < 60; c++) cycle(0, 0, 1);
`ifdef HOPPER_TIMEOUT_EN
    async_reset();
    m_off = 1;
    cycle(1, 1000, 0);
    nv = 0;
    for (int c = 0; c < 400 && o_fault !== 1'b1; c++) begin
      if (o_hopper_valid) nv++;
      cycle(0, 0, 0);
    end
    chk("to_fault", 32'(o_fault), 1);
    chk("to_noffer", nv, 256);
    repeat (5) cycle(1, 300, 1);
    chk("to_sticky", 32'(o_fault), 1);
    chk("to_busy", 32'(o_busy), 1);
    chk("to_valid", 32'(o_hopper_valid), 0);
    chk("to_rem", 32'(o_remaining), 1000);
    async_reset();
    chk("to_clear", 32'(o_fault), 0);
    m_off = 0;
`endif
    $display("test done: total=%0d bad=%0d", total_c, bad_c);
    $finish;
  end
endmodule
